beep_decoder: RTL and testbench
===============================

# beep_decoder

Receive-side counterpart of the countdown beeper. It watches the beeper's `en` and `b` lines, measures how many cycles pass between `en` being asserted and the beep starting, and recovers the loaded count value. It also checks the beep pulse width and reports malformed sequences. It sits beside the beeper as a self-check and readback block, and its outputs feed a status register or the testbench scoreboard.

## Interface
Parameters:
- `OFFSET`, default 1: fixed cycles between the first sampled `en`=1 and the first sampled `b`=1 when the loaded value is 0; subtracted from the measurement.
- `BEEP_LEN`, default 3: expected number of consecutive cycles `b` is sampled high.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: beeper enable, observed.
- `b`  in  1: beeper output, observed.
- `v_out`  out  8: last successfully recovered count value.
- `valid`  out  1: one-cycle pulse; `v_out` updated this cycle.
- `err`  out  1: one-cycle pulse; sequence rejected.
- `err_code`  out  2: reason for the last `err`; 01 timeout, 10 beep length, 11 early beep. Holds until the next `err`.
- `busy`  out  1: high in MEAS or BEEP.

## Operation
- States: IDLE, MEAS, BEEP, HOLD. Internal `cnt` 9 bits, `blen` 3 bits.
- IDLE:
  - `en`=1 and `b`=0 → MEAS, `cnt`=1.
  - `en`=1 and `b`=1 → `err` with code 11 → HOLD.
  - Otherwise stay.
- MEAS:
  - `en`=0 → IDLE; silent abort, no pulse.
  - `b`=1 → BEEP, `blen`=1, `cnt` frozen.
  - Otherwise `cnt`+1.
  - If `cnt` would exceed 255+OFFSET → `err` with code 01 → HOLD.
- BEEP:
  - `b`=1 and `en`=1 → `blen`+1, saturating at 7.
  - `b`=0 or `en`=0 → evaluate:
    - Pass if `blen`==BEEP_LEN: `valid`, `v_out` = `cnt`−OFFSET. If `cnt`<OFFSET, clamp the result to 0; if above 255, clamp to 255.
    - Fail otherwise: `err` with code 10.
    - Next state is HOLD if `en`=1, else IDLE.
- HOLD: `en`=0 → IDLE. `b` is ignored.
- `valid` and `err` are never high in the same cycle.
- Only one result (`valid` or `err`) is produced per `en` high period.

## Timing
- Reset values: state IDLE, `v_out`=0, `valid`=0, `err`=0, `err_code`=00, `busy`=0, `cnt`=0, `blen`=0.
- All outputs are registered. `valid` and `err` rise one clock after the edge that samples the terminating condition, and stay high for exactly one cycle.
- Inputs are sampled on posedge only; no synchronizers, since both lines come from the same clock domain.
- `busy` follows the registered state.
- `rst_n` low mid-measurement: immediate return to reset values, with no pulse emitted on release.
- `en` falling and `b` rising on the same edge while in MEAS: the abort wins.
- `en` falling while in BEEP with `blen`==BEEP_LEN: counts as a pass.
- Back-to-back runs: `en` must be sampled low for at least one cycle, which passes through IDLE.

## Configuration
- Macro: `BEEP_DECODER_LEN_CHECK_EN`.
- Defined: the beep-length check is active as described above, and code 10 can occur.
- Undefined: the BEEP exit always passes (`valid`), `blen` logic is removed, and code 10 is never produced.

## Test plan
- Nominal readback, OFFSET=1: `en` high, `b` low for 6 cycles, then high 3 cycles, then low → one `valid` pulse, `v_out`=5, `err`=0, `busy` low after.
- Zero value: `en` high, `b` high on the 2nd sampled cycle for 3 cycles → `valid`, `v_out`=0.
- Timeout: `en` high with `b` held low for 300 cycles → `err` with code 01 at cycle 257, no `valid`, then HOLD until `en`=0.
- Short beep, macro defined: `b` high for 2 cycles after 10 low cycles → `err` with code 10 and `v_out` unchanged. With the macro undefined → `valid`, `v_out`=9.
- Abort and early beep:
  - `en` dropped after 4 cycles in MEAS → no pulse, return to IDLE.
  - `en` and `b` high on the same first cycle → `err` with code 11.
- Reset mid-run: `rst_n` low for 1 cycle during BEEP → all outputs 0, and the next full sequence with value 7 yields `v_out`=7.

Source files
------------

// File: rtl/beep_decoder_if.sv
// Observation bus between the countdown beeper and its decoder.
// The beeper side drives en/b; the decoder side drives readback and status.
interface beep_decoder_if;
  logic       en;
  logic       b;
  logic [7:0] v_out;
  logic       valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output en, b,
    input  v_out, valid, err, err_code, busy
  );

  modport slave (
    input  en, b,
    output v_out, valid, err, err_code, busy
  );
endinterface

// File: rtl/beep_decoder.sv
// Recovers a beeper's loaded count from the en-to-beep delay; registered outputs, one pulse per en period.
// Optional beep-length check under `BEEP_DECODER_LEN_CHECK_EN (undefined: every beep exit passes).
module beep_decoder #(
  parameter int OFFSET   = 1,
  parameter int BEEP_LEN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  beep_decoder_if.slave   bus
);

  localparam int CNT_MAX = 255 + OFFSET;

  typedef enum logic [1:0] {IDLE, MEAS, BEEP, HOLD} state_t;

  state_t     state;
  logic [8:0] cnt;
  logic [7:0] v_out_q;
  logic       valid_q;
  logic       err_q;
  logic [1:0] err_code_q;
  logic       busy_q;

  logic [9:0] cnt_inc;
  logic       timeout;
  logic [9:0] cnt_diff;
  logic [7:0] result;
  logic       len_ok;

  assign cnt_inc = {1'b0, cnt} + 10'd1;
  assign timeout = (cnt_inc > 10'(CNT_MAX));

  // Measured delay minus the fixed pipeline offset, clamped into 0..255.
  always_comb begin
    cnt_diff = 10'd0;
    result   = 8'd0;
    if ({1'b0, cnt} >= 10'(OFFSET)) begin
      cnt_diff = {1'b0, cnt} - 10'(OFFSET);
      result   = (cnt_diff > 10'd255) ? 8'd255 : cnt_diff[7:0];
    end
  end

`ifdef BEEP_DECODER_LEN_CHECK_EN
  logic [2:0] blen;
  assign len_ok = (blen == 3'(BEEP_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blen <= 3'd0;
    end else if (state == MEAS && bus.en && bus.b) begin
      blen <= 3'd1;
    end else if (state == BEEP && bus.en && bus.b && blen != 3'd7) begin
      blen <= blen + 3'd1;
    end
  end
`else
  assign len_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 9'd0;
      v_out_q    <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            if (bus.b) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b11;
              state      <= HOLD;
              busy_q     <= 1'b0;
            end else begin
              state  <= MEAS;
              cnt    <= 9'd1;
              busy_q <= 1'b1;
            end
          end
        end
        MEAS: begin
          // Abort takes priority over a beep starting on the same edge.
          if (!bus.en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.b) begin
            state  <= BEEP;
          end else if (timeout) begin
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
            state      <= HOLD;
            busy_q     <= 1'b0;
          end else begin
            cnt <= cnt_inc[8:0];
          end
        end
        BEEP: begin
          if (!(bus.en && bus.b)) begin
            if (len_ok) begin
              valid_q <= 1'b1;
              v_out_q <= result;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end
            state  <= bus.en ? HOLD : IDLE;
            busy_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.en) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.v_out    = v_out_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_beep_decoder.sv
// Drives en/b sequences built from (low cycles, beep cycles, ending) and checks against an arithmetic model.
module tb_beep_decoder;
  localparam int OFFSET   = 1;
  localparam int BEEP_LEN = 3;

  logic clk;
  logic rst_n;
  beep_decoder_if bus();

  beep_decoder #(.OFFSET(OFFSET), .BEEP_LEN(BEEP_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int pulse_cyc = -1;
  int drv_cyc = 0;
  int seq_start = 0;
  bit seq_first = 1'b0;

  // Expected persistent outputs
  int exp_vout = 0;
  int exp_code = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    check("valid_err_exclusive", 32'(bus.valid && bus.err), 32'd0);
    if (bus.valid) begin n_valid++; pulse_cyc = cyc; end
    if (bus.err)   begin n_err++;   pulse_cyc = cyc; end
  end

  task automatic step(input logic e, input logic bb);
    @(negedge clk);
    bus.en = e;
    bus.b  = bb;
    drv_cyc = cyc + 1;
    if (seq_first) begin
      seq_start = drv_cyc;
      seq_first = 1'b0;
    end
  endtask

  // kind: 0 none, 1 valid, 2 err; idx: 1-based sample number of the terminating sample
  task automatic model(input int d, input int l, output int kind, output int code,
                       output int v, output int idx);
    int eff_len;
    kind = 0; code = 0; v = 0; idx = 0;
    eff_len = (l > 7) ? 7 : l;
    if (d == 0) begin
      if (l > 0) begin kind = 2; code = 3; idx = 1; end
    end else if (d > 255 + OFFSET) begin
      kind = 2; code = 1; idx = 256 + OFFSET;
    end else if (l > 0) begin
      idx = d + l + 1;
`ifdef BEEP_DECODER_LEN_CHECK_EN
      if (eff_len != BEEP_LEN) begin kind = 2; code = 2; end
      else
`endif
      begin
        kind = 1;
        v = d - OFFSET;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
    end
  endtask

  // mode 0: beep ends by b falling with en high, then HOLD; mode 1: en falls (with b high)
  task automatic run_seq(input string tag, input int d, input int l, input int mode);
    int kind, code, v, idx;
    model(d, l, kind, code, v, idx);
    n_valid = 0; n_err = 0; pulse_cyc = -1;
    seq_first = 1'b1;
    for (int i = 0; i < d; i++) step(1'b1, 1'b0);
    if (d >= 2 && d <= 256 + OFFSET) check({tag, "_busy_meas"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < l; i++) step(1'b1, 1'b1);
    if (mode == 1) begin
      step(1'b0, 1'b1);
    end else begin
      if (l > 0 || d == 0) begin
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
      end
      step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    if (kind == 1) exp_vout = v;
    if (kind == 2) exp_code = code;
    check({tag, "_nvalid"}, 32'(n_valid), (kind == 1) ? 32'd1 : 32'd0);
    check({tag, "_nerr"},   32'(n_err),   (kind == 2) ? 32'd1 : 32'd0);
    check({tag, "_vout"},   32'(bus.v_out), 32'(exp_vout));
    check({tag, "_code"},   32'(bus.err_code), 32'(exp_code));
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    if (kind != 0) check({tag, "_pulse_cyc"}, 32'(pulse_cyc), 32'(seq_start + idx - 1));
  endtask

  initial begin
    int d, l, m;
    bus.en = 1'b0;
    bus.b  = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_vout",  32'(bus.v_out), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    check("rst_code",  32'(bus.err_code), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    run_seq("nominal",     6, 3, 0);
    run_seq("zero",        1, 3, 0);
    run_seq("timeout",   300, 0, 0);
    run_seq("short_beep", 10, 2, 0);
    run_seq("abort",       4, 0, 0);
    run_seq("abort_b",     4, 0, 1);
    run_seq("early",       0, 3, 0);
    run_seq("en_fall_pass", 8, 3, 1);
    run_seq("max_value", 256, 3, 0);
    run_seq("first_tmo", 257, 3, 0);
    run_seq("long_beep",   5, 9, 0);

    // Reset asserted during BEEP
    n_valid = 0; n_err = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.b  = 1'b0;
    #1;
    check("mid_rst_vout",  32'(bus.v_out), 32'd0);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_err",   32'(bus.err), 32'd0);
    check("mid_rst_code",  32'(bus.err_code), 32'd0);
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_vout = 0;
    exp_code = 0;
    repeat (3) step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("post_rst_pulses", 32'(n_valid + n_err), 32'd0);
    run_seq("after_rst", 8, 3, 0);

    for (int k = 0; k < 40; k++) begin
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(0, 20));
      l = $urandom_range(0, 8);
      m = $urandom_range(0, 1);
      run_seq($sformatf("rand%0d", k), d, l, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
